mem_seq: RTL and testbench

MEM_SEQ -- requirements
Module: mem_seq

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_seq_if.sv | 28 ++
 rtl/mem_seq.sv | 138 +++++++++++++
 tb/tb_mem_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and widths for the memory access sequencer.
package mem_pkg;

  localparam int unsigned FIELD_W = 3;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned WORD_W  = 12;
  localparam int unsigned RAM_AW  = FIELD_W + ADDR_W;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_INCR  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    INCW = 3'd4,
    DONE = 3'd5
  } state_e;

  // 12-bit increment; 0o7777 wraps to 0o0000.
  function automatic logic [0:WORD_W-1] word_inc(input logic [0:WORD_W-1] w);
    return w + WORD_W'(1);
  endfunction

endpackage

// File: rtl/mem_seq_if.sv
// CPU-side request/response bundle of the memory sequencer.
interface mem_seq_if;
  import mem_pkg::*;

  logic                req;
  logic [1:0]          op;
  logic [0:FIELD_W-1]  field;
  logic [0:ADDR_W-1]   addr;
  logic [0:WORD_W-1]   wdata;
  logic [0:WORD_W-1]   rdata;
  logic                zero;
  logic                ack;
  logic                busy;
  logic                nxm;

  // Requester side.
  modport master (
    output req, op, field, addr, wdata,
    input  rdata, zero, ack, busy, nxm
  );

  // Sequencer side.
  modport slave (
    input  req, op, field, addr, wdata,
    output rdata, zero, ack, busy, nxm
  );

endinterface

// File: rtl/mem_seq.sv
// Memory access sequencer: read, write and read-increment-write against a
// synchronous single-port RAM that lives outside this module.
// Optional feature: define MEM_LIMIT_EN to flag accesses to fields at or
// above MEM_FIELDS as non-existent memory (no RAM write, reads return 0).
module mem_seq
  import mem_pkg::*;
#(
  parameter int unsigned MEM_FIELDS = 2
) (
  input  logic                clk,
  input  logic                reset,
  mem_seq_if.slave            bus,
  output logic [0:RAM_AW-1]   ram_addr,
  output logic [0:WORD_W-1]   ram_din,
  output logic                ram_we,
  input  logic [0:WORD_W-1]   ram_dout
);

`ifdef MEM_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  state_e              state_q;
  op_e                 op_q;
  logic                lim_q;
  logic [0:RAM_AW-1]   ram_addr_q;
  logic [0:WORD_W-1]   ram_din_q;
  logic                ram_we_q;
  logic [0:WORD_W-1]   rdata_q;
  logic                zero_q;
  logic                ack_q;
  logic                busy_q;
  logic                nxm_q;

  op_e                 op_c;
  op_e                 op_norm_c;
  logic                lim_c;
  logic [0:WORD_W-1]   inc_c;
  logic [0:WORD_W-1]   cap_val_c;

  // Request decode: reserved op behaves as read; field limit check when enabled.
  always_comb begin
    op_c      = op_e'(bus.op);
    op_norm_c = (op_c == OP_RSVD) ? OP_READ : op_c;
    lim_c     = LIMIT_EN && (32'(bus.field) >= MEM_FIELDS);
    inc_c     = word_inc(ram_dout);
    cap_val_c = (op_q == OP_INCR) ? inc_c : ram_dout;
  end

  // Access sequencer with registered outputs; RAM write strobe is set on entry
  // to WR/INCW so it is high for exactly that one state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_READ;
      lim_q      <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      rdata_q    <= '0;
      zero_q     <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      nxm_q      <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      ram_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req) begin
            op_q       <= op_norm_c;
            lim_q      <= lim_c;
            ram_addr_q <= {bus.field, bus.addr};
            ram_din_q  <= bus.wdata;
            busy_q     <= 1'b1;
            if (op_norm_c == OP_WRITE) begin
              state_q  <= WR;
              ram_we_q <= !lim_c;
            end else begin
              state_q  <= RD;
            end
          end
        end
        WR: begin
          state_q <= DONE;
          ack_q   <= 1'b1;
          zero_q  <= 1'b0;
          nxm_q   <= lim_q;
        end
        RD: begin
          state_q <= CAP;
        end
        CAP: begin
          nxm_q <= lim_q;
          if (lim_q) begin
            rdata_q <= '0;
            zero_q  <= 1'b1;
          end else begin
            rdata_q <= cap_val_c;
            zero_q  <= (cap_val_c == '0);
          end
          if (op_q == OP_INCR) begin
            ram_din_q <= inc_c;
            ram_we_q  <= !lim_q;
            state_q   <= INCW;
          end else begin
            ack_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        INCW: begin
          state_q <= DONE;
          ack_q   <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;
  assign bus.rdata = rdata_q;
  assign bus.zero  = zero_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.nxm   = nxm_q;

endmodule

// File: tb/tb_mem_seq.sv
// Self-checking bench for mem_seq with a bench-side synchronous RAM and a
// word-level reference model of memory contents and access results.
module tb_mem_seq;
  import mem_pkg::*;

`ifdef MEM_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif
  localparam int unsigned NFIELDS = 2;

  logic        clk;
  logic        reset;
  logic [0:14] ram_addr;
  logic [0:11] ram_din;
  logic        ram_we;
  logic [0:11] ram_dout;

  mem_seq_if bus ();

  mem_seq #(.MEM_FIELDS(NFIELDS)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-up contents of every RAM word, known to both RAM and model.
  function automatic logic [11:0] init_f(input int unsigned a);
    return 12'((a * 32'd2654435761) >> 20);
  endfunction

  // Bench RAM: one-cycle read latency, write on ram_we.
  logic [11:0] ram_mem [0:32767];
  bit          written [0:32767];
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_din;
      written[ram_addr] <= 1'b1;
    end
    ram_dout <= written[ram_addr] ? ram_mem[ram_addr] : init_f(32'(ram_addr));
  end

  function automatic logic [11:0] ram_peek(input logic [14:0] a);
    return written[a] ? ram_mem[a] : init_f(32'(a));
  endfunction

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [11:0] ref_mem [0:32767];
  logic [11:0] exp_rdata;
  logic        exp_zero;
  logic        exp_nxm;
  int          exp_lat;
  int          exp_we;
  logic [11:0] exp_wd;

  // Results of one driven access.
  int          lat;
  int          we_cnt;
  logic [14:0] we_addr;
  logic [11:0] we_data;

  task automatic predict(input logic [1:0] op, input logic [2:0] f,
                         input logic [11:0] a, input logic [11:0] wd);
    logic [14:0] la;
    logic        nx;
    logic [11:0] v;
    la = {f, a};
    nx = LIMIT && (32'(f) >= NFIELDS);
    exp_nxm = nx;
    if (op == 2'b01) begin
      exp_lat  = 2;
      exp_we   = nx ? 0 : 1;
      exp_wd   = wd;
      exp_zero = 1'b0;
      if (!nx) ref_mem[la] = wd;
    end else if (op == 2'b10) begin
      exp_lat = 4;
      exp_we  = nx ? 0 : 1;
      v       = nx ? 12'd0 : 12'((int'(ref_mem[la]) + 1) % 4096);
      exp_wd  = v;
      exp_rdata = v;
      exp_zero  = (v == 12'd0);
      if (!nx) ref_mem[la] = v;
    end else begin
      exp_lat   = 3;
      exp_we    = 0;
      v         = nx ? 12'd0 : ref_mem[la];
      exp_wd    = 12'd0;
      exp_rdata = v;
      exp_zero  = (v == 12'd0);
    end
  endtask

  // Issue one request from IDLE, drop req after accept, scramble inputs while busy.
  task automatic run_op(input logic [1:0] op, input logic [2:0] f,
                        input logic [11:0] a, input logic [11:0] wd);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.req = 1'b1; bus.op = op; bus.field = f; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    lat = 0; we_cnt = 0; we_addr = '0; we_data = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      bus.req   = 1'b0;
      bus.op    = 2'($urandom);
      bus.field = 3'($urandom);
      bus.addr  = 12'($urandom);
      bus.wdata = 12'($urandom);
      if (ram_we) begin
        we_cnt++;
        we_addr = ram_addr;
        we_data = ram_din;
      end
      if (bus.ack) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int k;
    reset = 1'b1;
    bus.req = 1'b1; bus.op = 2'b00; bus.field = 3'd0; bus.addr = 12'o0005; bus.wdata = 12'o1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.rdata, bus.zero, bus.ack, bus.busy, bus.nxm, ram_addr, ram_din, ram_we} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %0h exp 0",
               {bus.rdata, bus.zero, bus.ack, bus.busy, bus.nxm, ram_addr, ram_din, ram_we});
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_accept got busy=%0b exp 1", bus.busy);
    end
    predict(2'b00, 3'd0, 12'o0005, 12'o0);
    k = 1;
    while (!bus.ack && k < 16) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== 3 || bus.rdata !== exp_rdata) begin
      errors++;
      $display("FAIL reset_first_read got lat=%0d rdata=%0o exp lat=3 rdata=%0o", k, bus.rdata, exp_rdata);
    end
  endtask

  task automatic test_write_basic();
    logic [11:0] prev;
    prev = exp_rdata;
    predict(2'b01, 3'd0, 12'o0000, 12'o7777);
    run_op(2'b01, 3'd0, 12'o0000, 12'o7777);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL wr_latency got %0d exp 2", lat); end
    checks++;
    if (we_cnt !== 1 || we_addr !== 15'o00000) begin
      errors++; $display("FAIL wr_strobe got cnt=%0d addr=%0o exp cnt=1 addr=0", we_cnt, we_addr);
    end
    checks++;
    if (ram_peek(15'o00000) !== 12'o7777) begin
      errors++; $display("FAIL wr_ram got %0o exp 7777", ram_peek(15'o00000));
    end
    checks++;
    if (bus.rdata !== prev || bus.zero !== 1'b0) begin
      errors++; $display("FAIL wr_rdata_hold got %0o/%0b exp %0o/0", bus.rdata, bus.zero, prev);
    end
  endtask

  task automatic test_read_after_write();
    predict(2'b01, 3'd1, 12'o0000, 12'o5252);
    run_op(2'b01, 3'd1, 12'o0000, 12'o5252);
    predict(2'b00, 3'd1, 12'o0000, 12'o0);
    run_op(2'b00, 3'd1, 12'o0000, 12'o0);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d exp 3", lat); end
    checks++;
    if (bus.rdata !== 12'o5252 || bus.zero !== 1'b0 || we_cnt !== 0) begin
      errors++; $display("FAIL rd_data got %0o/%0b we=%0d exp 5252/0 we=0", bus.rdata, bus.zero, we_cnt);
    end
  endtask

  task automatic test_incr_wrap();
    predict(2'b01, 3'd1, 12'o7777, 12'o7777);
    run_op(2'b01, 3'd1, 12'o7777, 12'o7777);
    predict(2'b10, 3'd1, 12'o7777, 12'o0);
    run_op(2'b10, 3'd1, 12'o7777, 12'o0);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL inc_latency got %0d exp 4", lat); end
    checks++;
    if (bus.rdata !== 12'o0000 || bus.zero !== 1'b1) begin
      errors++; $display("FAIL inc_wrap got %0o/%0b exp 0/1", bus.rdata, bus.zero);
    end
    checks++;
    if (we_cnt !== 1 || we_addr !== 15'o17777 || ram_peek(15'o17777) !== 12'o0000) begin
      errors++; $display("FAIL inc_writeback got cnt=%0d addr=%0o ram=%0o exp 1/17777/0",
                         we_cnt, we_addr, ram_peek(15'o17777));
    end
  endtask

  task automatic test_limit();
    predict(2'b01, 3'd2, 12'o0000, 12'o5252);
    run_op(2'b01, 3'd2, 12'o0000, 12'o5252);
    checks++;
    if (bus.nxm !== exp_nxm || we_cnt !== exp_we || lat !== 2) begin
      errors++; $display("FAIL lim_write got nxm=%0b we=%0d lat=%0d exp nxm=%0b we=%0d lat=2",
                         bus.nxm, we_cnt, lat, exp_nxm, exp_we);
    end
    predict(2'b00, 3'd2, 12'o0000, 12'o0);
    run_op(2'b00, 3'd2, 12'o0000, 12'o0);
    checks++;
    if (bus.nxm !== exp_nxm || bus.rdata !== exp_rdata || bus.zero !== exp_zero || lat !== 3) begin
      errors++; $display("FAIL lim_read got nxm=%0b rdata=%0o zero=%0b lat=%0d exp %0b/%0o/%0b/3",
                         bus.nxm, bus.rdata, bus.zero, lat, exp_nxm, exp_rdata, exp_zero);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [2:0]  f;
    logic [11:0] a, wd;
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      f  = 3'($urandom_range(0, 3));
      a  = 12'($urandom_range(0, 7));
      wd = ($urandom_range(0, 7) == 0) ? 12'o0000 : 12'($urandom);
      predict(op, f, a, wd);
      run_op(op, f, a, wd);
      checks++;
      if (lat !== exp_lat || bus.rdata !== exp_rdata || bus.zero !== exp_zero || bus.nxm !== exp_nxm) begin
        errors++;
        $display("FAIL rand_%0d op=%0d got lat=%0d rdata=%0o zero=%0b nxm=%0b exp %0d/%0o/%0b/%0b",
                 n, op, lat, bus.rdata, bus.zero, bus.nxm, exp_lat, exp_rdata, exp_zero, exp_nxm);
      end
      checks++;
      if (we_cnt !== exp_we || (exp_we == 1 && (we_addr !== {f, a} || we_data !== exp_wd))) begin
        errors++;
        $display("FAIL rand_we_%0d got cnt=%0d addr=%0o data=%0o exp cnt=%0d addr=%0o data=%0o",
                 n, we_cnt, we_addr, we_data, exp_we, {f, a}, exp_wd);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] orig;
    int          bad;
    orig = ref_mem[15'o00123];
    @(negedge clk);
    while (bus.busy) @(negedge clk);
    bus.req = 1'b1; bus.op = 2'b10; bus.field = 3'd0; bus.addr = 12'o0123; bus.wdata = 12'o0;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.rdata, bus.zero, bus.ack, bus.busy, bus.nxm, ram_addr, ram_din, ram_we} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got %0h exp 0",
               {bus.rdata, bus.zero, bus.ack, bus.busy, bus.nxm, ram_addr, ram_din, ram_we});
    end
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ram_we || bus.ack) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rstmid_no_activity got %0d exp 0", bad); end
    exp_rdata = 12'o0;
    predict(2'b00, 3'd0, 12'o0123, 12'o0);
    run_op(2'b00, 3'd0, 12'o0123, 12'o0);
    checks++;
    if (bus.rdata !== orig || ram_peek(15'o00123) !== orig) begin
      errors++; $display("FAIL rstmid_preserved got %0o ram=%0o exp %0o", bus.rdata, ram_peek(15'o00123), orig);
    end
  endtask

  task automatic test_back_to_back();
    int ack1, ack2, wes;
    logic [11:0] w1, w2;
    w1 = 12'($urandom); w2 = 12'($urandom);
    ack1 = 0; ack2 = 0; wes = 0;
    @(negedge clk);
    while (bus.busy) @(negedge clk);
    bus.req = 1'b1; bus.op = 2'b01; bus.field = 3'd0; bus.addr = 12'o0040; bus.wdata = w1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ram_we) wes++;
      if (bus.ack) begin
        if (ack1 == 0) begin
          ack1 = c;
          bus.addr = 12'o0041; bus.wdata = w2;
        end else begin
          ack2 = c;
          bus.req = 1'b0;
          break;
        end
      end
    end
    bus.req = 1'b0;
    predict(2'b01, 3'd0, 12'o0040, w1);
    predict(2'b01, 3'd0, 12'o0041, w2);
    checks++;
    if (ack1 !== 2 || ack2 - ack1 !== 3) begin
      errors++; $display("FAIL b2b_spacing got ack1=%0d ack2=%0d exp 2/5", ack1, ack2);
    end
    checks++;
    if (wes !== 2 || ram_peek(15'o00040) !== w1 || ram_peek(15'o00041) !== w2) begin
      errors++; $display("FAIL b2b_data got we=%0d m0=%0o m1=%0o exp 2/%0o/%0o",
                         wes, ram_peek(15'o00040), ram_peek(15'o00041), w1, w2);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_no_repeat got busy=%0b exp 0", bus.busy); end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ref_mem[i] = init_f(32'(i));
    exp_rdata = 12'o0; exp_zero = 1'b0; exp_nxm = 1'b0;
    exp_lat = 0; exp_we = 0; exp_wd = '0;
    reset = 1'b1;
    bus.req = 1'b0; bus.op = 2'b00; bus.field = '0; bus.addr = '0; bus.wdata = '0;
    test_reset();
    test_write_basic();
    test_read_after_write();
    test_incr_wrap();
    test_limit();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no completion exp finish");
    $fatal(1);
  end

endmodule
